// File: rtl/snd_dma_pkg.sv
// Shared types and defaults for the sound DMA controller.
package snd_dma_pkg;

   localparam int unsigned NCH_DEFAULT = 2;
   localparam int unsigned AW_DEFAULT  = 21;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chan_state_e;

endpackage

// File: rtl/snd_dma_chan.sv
// One sound DMA channel: frame FSM, start/end shadows and the fetch pointer.
module snd_dma_chan
   import snd_dma_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT
) (
   input  logic          clk32,
   input  logic          por,
   input  logic          sndon_i,
   input  logic          sfrep_i,
   input  logic [AW-1:0] sfstart_i,
   input  logic [AW-1:0] sfend_i,
   input  logic          grant_i,
   output chan_state_e   state_o,
   output logic [AW-1:0] ptr_o,
   output logic          frame_end_o
);

   chan_state_e   state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] start_q, start_d;
   logic [AW-1:0] end_q, end_d;
   logic [AW-1:0] ptr_inc;

   assign ptr_inc     = ptr_q + AW'(1);
   assign frame_end_o = grant_i && (state_q == RUN) && (ptr_inc == end_q);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      start_d = start_q;
      end_d   = end_q;
      if (!sndon_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (sfstart_i < sfend_i) begin
                  state_d = RUN;
                  start_d = sfstart_i;
                  end_d   = sfend_i;
                  ptr_d   = sfstart_i;
               end else begin
                  state_d = DONE;
               end
            end
            RUN: begin
               if (grant_i) begin
                  ptr_d = ptr_inc;
                  if (ptr_inc == end_q) begin
                     // Repeat re-reads the inputs here, so mid-frame edits land at the boundary.
                     if (sfrep_i) begin
                        start_d = sfstart_i;
                        end_d   = sfend_i;
                        ptr_d   = sfstart_i;
                        state_d = (sfstart_i < sfend_i) ? RUN : DONE;
                     end else begin
                        state_d = DONE;
                     end
                  end
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous to clk32.
   always_ff @(posedge clk32) begin
      if (por) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         start_q <= '0;
         end_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         start_q <= start_d;
         end_q   <= end_d;
      end
   end

   assign state_o = state_q;
   assign ptr_o   = ptr_q;

endmodule

// File: rtl/snd_dma_ctl.sv
// Sound DMA controller: NCH channels sharing one memory slot via a round-robin
// arbiter, with registered fetch strobe, channel index, address and interrupts.
module snd_dma_ctl
   import snd_dma_pkg::*;
#(
   parameter  int unsigned NCH = NCH_DEFAULT,
   parameter  int unsigned AW  = AW_DEFAULT,
   localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk32,
   input  logic              por,
   input  logic              slot_en,
   input  logic [NCH-1:0]    sndon,
   input  logic [NCH-1:0]    sfrep,
   input  logic [NCH-1:0]    sreq,
   input  logic [NCH*AW-1:0] sfstart,
   input  logic [NCH*AW-1:0] sfend,
   output logic              sgrant,
   output logic [CW-1:0]     sch,
   output logic [AW-1:0]     sadr,
   output logic [NCH-1:0]    sframe,
   output logic [NCH-1:0]    sint,
   output logic [NCH-1:0]    stoff
);

   chan_state_e    state_w [NCH];
   logic [AW-1:0]  ptr_w   [NCH];
   logic [NCH-1:0] eligible_w;
   logic [NCH-1:0] frame_end_w;
   logic [NCH-1:0] gnt_vec_d;

   logic           sgrant_q, sgrant_d;
   logic [CW-1:0]  sch_q, sch_d;
   logic [AW-1:0]  sadr_q, sadr_d;
   logic [NCH-1:0] sint_q;
   logic [CW-1:0]  rr_q, rr_d;
   logic [CW-1:0]  idx_c;

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      snd_dma_chan #(.AW(AW)) u_chan (
         .clk32       (clk32),
         .por         (por),
         .sndon_i     (sndon[k]),
         .sfrep_i     (sfrep[k]),
         .sfstart_i   (sfstart[k*AW +: AW]),
         .sfend_i     (sfend[k*AW +: AW]),
         .grant_i     (gnt_vec_d[k]),
         .state_o     (state_w[k]),
         .ptr_o       (ptr_w[k]),
         .frame_end_o (frame_end_w[k])
      );

      assign eligible_w[k] = (state_w[k] == RUN) && sreq[k] && sndon[k];
      assign sframe[k]     = (state_w[k] == RUN);
      assign stoff[k]      = (state_w[k] == DONE);
   end

   // rr_q holds the first channel to consider, i.e. one past the last grant.
   always_comb begin
      gnt_vec_d = '0;
      sgrant_d  = 1'b0;
      sch_d     = '0;
      sadr_d    = '0;
      rr_d      = rr_q;
      idx_c     = '0;
      if (slot_en) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            idx_c = CW'((32'(rr_q) + i) % NCH);
            if (!sgrant_d && eligible_w[idx_c]) begin
               sgrant_d         = 1'b1;
               gnt_vec_d[idx_c] = 1'b1;
               sch_d            = idx_c;
               sadr_d           = ptr_w[idx_c];
               rr_d             = (idx_c == CW'(NCH - 1)) ? '0 : idx_c + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk32) begin
      if (por) begin
         sgrant_q <= 1'b0;
         sch_q    <= '0;
         sadr_q   <= '0;
         sint_q   <= '0;
         rr_q     <= '0;
      end else begin
         sgrant_q <= sgrant_d;
         sch_q    <= sch_d;
         sadr_q   <= sadr_d;
         sint_q   <= frame_end_w;
         rr_q     <= rr_d;
      end
   end

   assign sgrant = sgrant_q;
   assign sch    = sch_q;
   assign sadr   = sadr_q;
   assign sint   = sint_q;

endmodule

// File: tb/tb_snd_dma_ctl.sv
// Directed scoreboard bench for snd_dma_ctl with two channels.
module tb_snd_dma_ctl;

   localparam int NCH = 2;
   localparam int AW  = 21;
   localparam int CW  = 1;

   logic              clk32 = 1'b0;
   logic              por;
   logic              slot_en;
   logic [NCH-1:0]    sndon, sfrep, sreq;
   logic [NCH*AW-1:0] sfstart, sfend;
   logic              sgrant;
   logic [CW-1:0]     sch;
   logic [AW-1:0]     sadr;
   logic [NCH-1:0]    sframe, sint, stoff;

   typedef struct {
      logic           grant;
      logic [CW-1:0]  ch;
      logic [AW-1:0]  adr;
      logic [NCH-1:0] sint;
   } exp_t;

   exp_t  sb_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   string step  = "init";

   snd_dma_ctl #(.NCH(NCH), .AW(AW)) dut (
      .clk32   (clk32),
      .por     (por),
      .slot_en (slot_en),
      .sndon   (sndon),
      .sfrep   (sfrep),
      .sreq    (sreq),
      .sfstart (sfstart),
      .sfend   (sfend),
      .sgrant  (sgrant),
      .sch     (sch),
      .sadr    (sadr),
      .sframe  (sframe),
      .sint    (sint),
      .stoff   (stoff)
   );

   always #5 clk32 = ~clk32;

   task automatic tick(input int n);
      repeat (n) @(negedge clk32);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", step, tag, obs, exp);
      end
   endtask

   task automatic set_chan(input int k, input int start, input int stop);
      sfstart[k*AW +: AW] = AW'(start);
      sfend[k*AW +: AW]   = AW'(stop);
   endtask

   // One slot strobe; the expectation is queued at drive time and retired one cycle later.
   task automatic slot(input logic g, input int ch, input int adr, input logic [NCH-1:0] si);
      exp_t e;
      exp_t got;
      e.grant = g;
      e.ch    = CW'(ch);
      e.adr   = AW'(adr);
      e.sint  = si;
      slot_en = 1'b1;
      sb_q.push_back(e);
      @(negedge clk32);
      slot_en = 1'b0;
      got = sb_q.pop_front();
      check("sgrant", 32'(sgrant), 32'(got.grant));
      check("sint", 32'(sint), 32'(got.sint));
      if (got.grant) begin
         check("sch", 32'(sch), 32'(got.ch));
         check("sadr", 32'(sadr), 32'(got.adr));
      end
   endtask

   initial begin
      por     = 1'b1;
      slot_en = 1'b0;
      sndon   = '0;
      sfrep   = '0;
      sreq    = '0;
      sfstart = '0;
      sfend   = '0;
      tick(2);

      step = "reset";
      check("sgrant", 32'(sgrant), 32'd0);
      check("sch", 32'(sch), 32'd0);
      check("sadr", 32'(sadr), 32'd0);
      check("sint", 32'(sint), 32'd0);
      check("stoff", 32'(stoff), 32'd0);
      check("sframe", 32'(sframe), 32'd0);
      por = 1'b0;

      step = "rr2";
      set_chan(0, 'h100, 'h104);
      set_chan(1, 'h300, 'h310);
      sreq  = 2'b11;
      sndon = 2'b11;
      tick(1);
      check("sframe", 32'(sframe), 32'h3);
      slot(1'b1, 0, 'h100, 2'b00);
      slot(1'b1, 1, 'h300, 2'b00);
      slot(1'b1, 0, 'h101, 2'b00);
      slot(1'b1, 1, 'h301, 2'b00);
      sreq = 2'b01;
      slot(1'b1, 0, 'h102, 2'b00);
      slot(1'b1, 0, 'h103, 2'b01);
      check("stoff", 32'(stoff), 32'h1);
      check("sframe", 32'(sframe), 32'h2);
      sndon = 2'b00;
      tick(1);
      check("sframe_off", 32'(sframe), 32'h0);
      check("stoff_off", 32'(stoff), 32'h0);

      step = "single";
      set_chan(0, 'h100, 'h104);
      sfrep = 2'b00;
      sndon = 2'b01;
      tick(1);
      slot(1'b1, 0, 'h100, 2'b00);
      slot(1'b1, 0, 'h101, 2'b00);
      slot(1'b1, 0, 'h102, 2'b00);
      slot(1'b1, 0, 'h103, 2'b01);
      slot(1'b0, 0, 0, 2'b00);
      slot(1'b0, 0, 0, 2'b00);
      check("stoff", 32'(stoff), 32'h1);
      check("sframe", 32'(sframe), 32'h0);

      step = "repeat";
      sndon = 2'b00;
      tick(1);
      check("stoff_idle", 32'(stoff), 32'h0);
      sfrep = 2'b01;
      sndon = 2'b01;
      tick(1);
      slot(1'b1, 0, 'h100, 2'b00);
      slot(1'b1, 0, 'h101, 2'b00);
      set_chan(0, 'h200, 'h202);
      slot(1'b1, 0, 'h102, 2'b00);
      slot(1'b1, 0, 'h103, 2'b01);
      slot(1'b1, 0, 'h200, 2'b00);
      slot(1'b1, 0, 'h201, 2'b01);
      slot(1'b1, 0, 'h200, 2'b00);
      check("sframe", 32'(sframe), 32'h1);

      step = "abort";
      sndon = 2'b00;
      tick(1);
      sfrep = 2'b00;
      set_chan(0, 'h100, 'h104);
      sndon = 2'b01;
      tick(1);
      slot(1'b1, 0, 'h100, 2'b00);
      sndon = 2'b00;
      slot(1'b0, 0, 0, 2'b00);
      check("sframe", 32'(sframe), 32'h0);
      check("stoff", 32'(stoff), 32'h0);
      sndon = 2'b01;
      tick(1);
      slot(1'b1, 0, 'h100, 2'b00);

      step = "empty_wrap";
      sndon = 2'b00;
      tick(1);
      set_chan(0, 'h1FFFFF, 'h1FFFFE);
      sndon = 2'b01;
      tick(1);
      check("stoff", 32'(stoff), 32'h1);
      check("sframe", 32'(sframe), 32'h0);
      slot(1'b0, 0, 0, 2'b00);

      step = "empty_eq";
      sndon = 2'b00;
      tick(1);
      check("stoff_idle", 32'(stoff), 32'h0);
      set_chan(0, 'h50, 'h50);
      sndon = 2'b01;
      tick(1);
      check("stoff", 32'(stoff), 32'h1);
      slot(1'b0, 0, 0, 2'b00);

      step = "por_mid";
      sndon = 2'b00;
      tick(1);
      set_chan(0, 'h100, 'h104);
      sndon = 2'b01;
      tick(1);
      slot(1'b1, 0, 'h100, 2'b00);
      slot(1'b1, 0, 'h101, 2'b00);
      por     = 1'b1;
      slot_en = 1'b1;
      tick(1);
      por     = 1'b0;
      slot_en = 1'b0;
      check("sgrant", 32'(sgrant), 32'd0);
      check("sch", 32'(sch), 32'd0);
      check("sadr", 32'(sadr), 32'd0);
      check("sint", 32'(sint), 32'd0);
      check("sframe", 32'(sframe), 32'd0);
      check("stoff", 32'(stoff), 32'd0);
      tick(1);
      check("sframe_restart", 32'(sframe), 32'h1);
      slot(1'b1, 0, 'h100, 2'b00);

      step = "end";
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/snd_dma_ctl.md
SND_DMA_CTL -- requirements
Module: snd_dma_ctl

Interface
REQ-001 Parameter NCH, default 2: number of sound DMA channels, range 1..8.
REQ-002 Parameter AW, default 21: word-address width of the frame pointers.
REQ-003 Port clk32  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port por  input  1: reset; it SHALL be synchronous and active-high.
REQ-005 Port slot_en  input  1: one-clk32 strobe marking a sound DMA memory slot.
REQ-006 Port sndon  input  NCH: per-channel DMA enable level.
REQ-007 Port sfrep  input  NCH: per-channel frame-repeat mode.
REQ-008 Port sreq  input  NCH: per-channel FIFO data request level.
REQ-009 Port sfstart  input  NCH*AW: per-channel frame start address, channel k at bits [k*AW +: AW].
REQ-010 Port sfend  input  NCH*AW: per-channel frame end address, exclusive, same packing.
REQ-011 Port sgrant  output  1: registered one-cycle fetch strobe.
REQ-012 Port sch  output  max(1,clog2(NCH)): channel index qualified by sgrant.
REQ-013 Port sadr  output  AW: fetch address qualified by sgrant.
REQ-014 Port sframe  output  NCH: channel is in RUN state.
REQ-015 Port sint  output  NCH: one-cycle frame-end interrupt pulse.
REQ-016 Port stoff  output  NCH: level; frame ended without repeat, or the frame was empty.

Function
REQ-017 Each channel SHALL implement states IDLE, RUN, DONE.
REQ-018 IDLE->RUN on the first clk32 cycle with sndon=1 and sfstart<sfend: latch start and end into shadow registers, set pointer=start.
REQ-019 IDLE->DONE, when sndon=1 and sfstart>=sfend: no fetch is issued and no sint pulse occurs.
REQ-020 RUN->IDLE and DONE->IDLE whenever sndon=0; this has priority over every other event in the same cycle.
REQ-021 On slot_en, arbitration SHALL pick one eligible channel, round-robin, starting after the last granted channel; eligible = RUN & sreq & sndon.
REQ-022 The grant SHALL appear on sgrant, sch and sadr=pointer exactly one clk32 after the slot_en cycle; no eligible channel gives sgrant=0.
REQ-023 The granted channel's pointer SHALL increment by 1, modulo 2^AW.
REQ-024 Frame end: when the granted pointer+1 equals the shadow end, assert sint[k] in the same cycle as that sgrant.
- If sfrep[k]=1: re-latch start/end from the inputs and stay RUN, with the new-start check of REQ-019 applied.
- Else: go to DONE.
REQ-025 Input start/end changes during RUN SHALL take effect only at the next frame boundary.
REQ-026 Outputs: sframe[k]=(state==RUN); stoff[k]=(state==DONE).
REQ-027 At most one sgrant SHALL occur per slot_en; slot_en strobes closer than 2 cycles are legal.

Reset
REQ-028 With por=1 at a clk32 edge, all channels SHALL be IDLE, pointers and shadows 0, the round-robin pointer 0, and sgrant, sch, sadr, sint, stoff, sframe all 0.
REQ-029 Reset mid-frame SHALL abort without an sint pulse; a channel with sndon held at 1 restarts from sfstart on the cycle after por falls.

Structure
REQ-030 Package snd_dma_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default NCH/AW constants.
REQ-031 Sub-module snd_dma_chan SHALL hold one channel's FSM, shadows and pointer; it is instantiated NCH times by generate, and the arbiter and output registers live in snd_dma_ctl.

Verification
REQ-032 NCH=1, start=0x100, end=0x104, sfrep=0, sreq=1, 6 slots -> sadr 0x100..0x103, sint on the 0x103 grant, stoff=1, no 5th or 6th grant.
REQ-033 Same setup with sfrep=1 and inputs changed to 0x200/0x202 mid-frame -> sequence 0x100..0x103, then 0x200, 0x201, 0x200, with sint after each 0x103 and each 0x201.
REQ-034 NCH=2, both channels eligible, 4 slots -> sch 0,1,0,1; drop sreq[1] -> sch 0,0.
REQ-035 sndon[0] falls in the same cycle as its slot_en -> no grant, state IDLE, no sint; re-raise sndon -> restart at 0x100.
REQ-036 start=0x1FFFFF, end=0x1FFFFE, and separately start=end=0x50 -> immediate DONE, stoff=1, no sgrant, no sint.
REQ-037 Assert por for 1 cycle mid-frame -> all outputs 0 next cycle; with sndon high, the frame restarts from start.
